// File: rtl/mux4_scan_ctrl.sv
// Select sequencer for a 4:1 mux: steps through enabled channels, dwells on each,
// captures y per channel on the last dwell cycle and reports a 4-bit snapshot.
module mux4_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [3:0]         chan_mask,
    input  logic               y_in,
    output logic               sel0,
    output logic               sel1,
    output logic               busy,
    output logic               done,
    output logic [3:0]         sample,
    output logic               sample_valid
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] last_q, last_d;
    logic [3:0]         mask_q, mask_d;
    logic [3:0]         sample_q, sample_d;
    logic               valid_q, valid_d;

    logic [3:0]         above_mask;
    logic               has_next;
    logic [1:0]         next_chan;
    logic [1:0]         first_chan;
    logic               dwell_end;

    function automatic logic [1:0] lowest_chan(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (m[k]) begin
                idx = 2'(k);
            end
        end
        return idx;
    endfunction

    // Enabled channels strictly above the current select, in the latched mask.
    assign above_mask = mask_q & (4'b1110 << sel_q);
    assign has_next   = |above_mask;
    assign next_chan  = lowest_chan(above_mask);
    assign first_chan = lowest_chan(chan_mask);
    assign dwell_end  = (cnt_q == last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= 2'd0;
            cnt_q    <= '0;
            last_q   <= '0;
            mask_q   <= 4'd0;
            sample_q <= 4'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            mask_q   <= mask_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (chan_mask != 4'd0) ? ST_SCAN : ST_FINISH;
                end
            end
            ST_SCAN: begin
                if (dwell_end && !has_next) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        mask_d   = mask_q;
        sample_d = sample_q;
        valid_d  = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sample_d = 4'd0;
                    cnt_d    = '0;
                    mask_d   = chan_mask;
                    // Store dwell_eff-1 so a zero dwell behaves as one cycle.
                    last_d   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
                    if (chan_mask != 4'd0) begin
                        sel_d   = first_chan;
                        valid_d = 1'b0;
                    end else begin
                        valid_d = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (dwell_end) begin
                    sample_d[sel_q] = y_in;
                    cnt_d           = '0;
                    if (has_next) begin
                        sel_d = next_chan;
                    end else begin
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        busy = (state_q == ST_SCAN);
        done = (state_q == ST_FINISH);
    end

    assign sel0         = sel_q[0];
    assign sel1         = sel_q[1];
    assign sample       = sample_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: a timeline model of the scan checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mux4_scan_ctrl;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dwell = '0;
    logic [3:0]    chan_mask = 4'd0;
    logic          y_in;
    logic          sel0, sel1, busy, done, sample_valid;
    logic [3:0]    sample;
    logic [3:0]    mux_data = 4'b0101;  // i0=1, i1=0, i2=1, i3=0

    int checks = 0;
    int errors = 0;

    mux4_scan_ctrl #(.DWELL_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dwell(dwell),
        .chan_mask(chan_mask), .y_in(y_in), .sel0(sel0), .sel1(sel1),
        .busy(busy), .done(done), .sample(sample), .sample_valid(sample_valid)
    );

    assign y_in = mux_data[{sel1, sel1 ? sel0 : sel0}];

    always #5 clk = ~clk;

    // Model: a scan is a timeline of t cycles since the accepting edge.
    bit         m_run = 0;
    int         m_t = 0, m_n = 0, m_d = 1;
    int         m_ch[4];
    logic [1:0] m_sel = 2'd0;
    logic [3:0] m_sample = 4'd0;
    logic       m_valid = 1'b0;

    always @(negedge rst_n) begin
        m_run = 0; m_t = 0; m_sel = 2'd0; m_sample = 4'd0; m_valid = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (m_run) begin
                m_t++;
                if (m_t <= m_n * m_d && (m_t % m_d) == 0)
                    m_sample[m_ch[m_t / m_d - 1]] = mux_data[m_ch[m_t / m_d - 1]];
                if (m_t < m_n * m_d) m_sel = 2'(m_ch[m_t / m_d]);
                if (m_t == m_n * m_d) m_valid = 1'b1;
                if (m_t > m_n * m_d) m_run = 0;
            end else if (start) begin
                m_d = (dwell == 0) ? 1 : int'(dwell);
                m_n = 0;
                for (int k = 0; k < 4; k++) if (chan_mask[k]) begin m_ch[m_n] = k; m_n++; end
                m_sample = 4'd0;
                m_run = 1;
                m_t = 0;
                if (m_n > 0) begin m_sel = 2'(m_ch[0]); m_valid = 1'b0; end
                else m_valid = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("model_sel", 8'({sel1, sel0}), 8'(m_sel));
        chk("model_busy", 8'(busy), 8'(m_run && m_t < m_n * m_d));
        chk("model_done", 8'(done), 8'(m_run && m_t == m_n * m_d));
        chk("model_sample", 8'(sample), 8'(m_sample));
        chk("model_valid", 8'(sample_valid), 8'(m_valid));
    end

    // Pulse start around one rising edge (E0); returns half a cycle after E0.
    task automatic kick(input logic [DW-1:0] d, input logic [3:0] m);
        @(negedge clk);
        dwell = d; chan_mask = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        bit seen = 0;
        for (int i = 0; i < bound; i++) begin
            if (done) begin seen = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: done not seen within %0d cycles", name, bound);
        end
    endtask

    task automatic full_scan_literal(input string tag);
        chk({tag, "_sel_e0"}, 8'({sel1, sel0}), 8'd0);
        chk({tag, "_busy"}, 8'(busy), 8'd1);
        chk({tag, "_valid_clr"}, 8'(sample_valid), 8'd0);
        repeat (4) @(negedge clk);
        chk({tag, "_sel_e4"}, 8'({sel1, sel0}), 8'd1);
        repeat (4) @(negedge clk);
        chk({tag, "_sel_e8"}, 8'({sel1, sel0}), 8'd2);
        repeat (4) @(negedge clk);
        chk({tag, "_sel_e12"}, 8'({sel1, sel0}), 8'd3);
        chk({tag, "_done_early"}, 8'(done), 8'd0);
        repeat (4) @(negedge clk);
        chk({tag, "_done"}, 8'(done), 8'd1);
        chk({tag, "_busy_off"}, 8'(busy), 8'd0);
        chk({tag, "_sample"}, 8'(sample), 8'b0101);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 8'(done), 8'd0);
        chk({tag, "_valid"}, 8'(sample_valid), 8'd1);
    endtask

    initial begin
        #1;
        chk("reset_sel", 8'({sel1, sel0}), 8'd0);
        chk("reset_busy", 8'(busy), 8'd0);
        chk("reset_sample", 8'(sample), 8'd0);
        chk("reset_valid", 8'(sample_valid), 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: all channels, dwell 4
        kick(8'd4, 4'b1111);
        full_scan_literal("t1");

        // 2: channels 1 and 3, dwell 2
        kick(8'd2, 4'b1010);
        chk("t2_sel_first", 8'({sel1, sel0}), 8'd1);
        repeat (2) @(negedge clk);
        chk("t2_sel_second", 8'({sel1, sel0}), 8'd3);
        repeat (2) @(negedge clk);
        chk("t2_done", 8'(done), 8'd1);
        chk("t2_sample", 8'(sample), 8'b0000);
        repeat (2) @(negedge clk);

        // 3: dwell 0 acts as 1
        kick(8'd0, 4'b0001);
        chk("t3_busy", 8'(busy), 8'd1);
        @(negedge clk);
        chk("t3_done", 8'(done), 8'd1);
        chk("t3_sample", 8'(sample), 8'b0001);
        repeat (2) @(negedge clk);

        // 4: empty mask goes straight to finish
        kick(8'd3, 4'b0000);
        chk("t4_done", 8'(done), 8'd1);
        chk("t4_busy", 8'(busy), 8'd0);
        chk("t4_sample", 8'(sample), 8'd0);
        chk("t4_valid", 8'(sample_valid), 8'd1);
        repeat (2) @(negedge clk);

        // 5: start re-pulsed and inputs changed mid-scan
        kick(8'd4, 4'b1111);
        fork
            full_scan_literal("t5");
            begin
                repeat (2) @(negedge clk);
                dwell = 8'd1; chan_mask = 4'b0001; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (5) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        repeat (2) @(negedge clk);

        // maximum dwell on a single channel
        kick(8'd255, 4'b0100);
        wait_done("tmax_done", 300);
        chk("tmax_sample", 8'(sample), 8'b0100);
        repeat (2) @(negedge clk);

        // 6: async reset mid-scan, then a clean full scan
        kick(8'd4, 4'b1111);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_sel", 8'({sel1, sel0}), 8'd0);
        chk("t6_busy", 8'(busy), 8'd0);
        chk("t6_done", 8'(done), 8'd0);
        chk("t6_sample", 8'(sample), 8'd0);
        chk("t6_valid", 8'(sample_valid), 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_idle_busy", 8'(busy), 8'd0);
        kick(8'd4, 4'b1111);
        full_scan_literal("t6");
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
